id_hd_bitstream_reader: RTL and testbench

ID_HD_BITSTREAM_READER -- requirements
Module: id_hd_bitstream_reader

---
 rtl/id_hd_bitstream_reader_if.sv | 21 ++
 rtl/id_hd_bitstream_reader.sv | 164 ++++++++++++++++
 tb/tb_id_hd_bitstream_reader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_hd_bitstream_reader_if.sv
// Memory-fetch and bit-peek/consume signals of the bitstream reader.
// The master modport is the reader; the slave modport is the memory/decoder side.
interface id_hd_bitstream_reader_if;
    logic        word_request;
    logic        inputready;
    logic [31:0] readdata;
    logic [15:0] peek_bits;
    logic        bits_valid;
    logic        consume;
    logic [4:0]  consume_length;

    modport master (
        output word_request, peek_bits, bits_valid,
        input  inputready, readdata, consume, consume_length
    );

    modport slave (
        input  word_request, peek_bits, bits_valid,
        output inputready, readdata, consume, consume_length
    );
endinterface

// File: rtl/id_hd_bitstream_reader.sv
// Byte-stuffed bitstream reader: fetches 32-bit words, removes 0xFF00 stuffing,
// detects markers, and serves up to 16 bits per cycle MSB-first.
module id_hd_bitstream_reader #(
    parameter int unsigned BUF_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ID_ByteCount,
    id_hd_bitstream_reader_if.master bus,
    output logic        marker_found,
    output logic [7:0]  marker_value,
    output logic        end_of_stream,
    output logic        underflow_error
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned POS_W  = 6;
    localparam int unsigned PEEK_W = 16;
    localparam int unsigned BYTE_W = 8;

    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  fetched_q, fetched_d;
    logic [31:0]       word_q, word_d;
    logic [2:0]        word_left_q, word_left_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic              ff_pend_q, ff_pend_d;
    logic              active_q, active_d;
    logic              marker_q, marker_d;
    logic [BYTE_W-1:0] mval_q, mval_d;
    logic              eos_q, eos_d;
    logic              uflow_q, uflow_d;

    logic              req_c;
    logic              consume_ok_c;
    logic              move_c;
    logic [POS_W-1:0]  pos_eff_c;
    logic [CNT_W-1:0]  remaining_c;
    logic              app_en_c;
    logic [BYTE_W-1:0] app_byte_c;
    logic [BYTE_W-1:0] byte_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            fetched_q   <= '0;
            word_q      <= '0;
            word_left_q <= '0;
            buf_q       <= '0;
            pos_q       <= '0;
            ff_pend_q   <= 1'b0;
            active_q    <= 1'b0;
            marker_q    <= 1'b0;
            mval_q      <= '0;
            eos_q       <= 1'b0;
            uflow_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            fetched_q   <= fetched_d;
            word_q      <= word_d;
            word_left_q <= word_left_d;
            buf_q       <= buf_d;
            pos_q       <= pos_d;
            ff_pend_q   <= ff_pend_d;
            active_q    <= active_d;
            marker_q    <= marker_d;
            mval_q      <= mval_d;
            eos_q       <= eos_d;
            uflow_q     <= uflow_d;
        end
    end

    always_comb begin
        count_d     = count_q;
        fetched_d   = fetched_q;
        word_d      = word_q;
        word_left_d = word_left_q;
        buf_d       = buf_q;
        ff_pend_d   = ff_pend_q;
        active_d    = active_q;
        marker_d    = marker_q;
        mval_d      = mval_q;
        eos_d       = eos_q;
        uflow_d     = uflow_q;
        app_en_c    = 1'b0;
        app_byte_c  = 8'hFF;
        byte_c      = word_q[7:0];
        remaining_c = count_q - fetched_q;

        req_c = (word_left_q == 3'd0) && (fetched_q < count_q) && !marker_q && !start;

        consume_ok_c = bus.consume && (bus.consume_length != 5'd0) &&
                       (bus.consume_length <= 5'd16) &&
                       ({1'b0, bus.consume_length} <= pos_q);
        pos_eff_c = consume_ok_c ? pos_q - {1'b0, bus.consume_length} : pos_q;
        pos_d     = pos_eff_c;
        if (bus.consume && !consume_ok_c) begin
            uflow_d = 1'b1;
        end

        // A byte may only enter when the post-consume buffer has room for 8 bits.
        move_c = (word_left_q != 3'd0) && !marker_q && (pos_eff_c <= POS_W'(24));

        if (req_c && bus.inputready) begin
            word_d      = bus.readdata;
            word_left_d = (remaining_c >= CNT_W'(4)) ? 3'd4 : 3'(remaining_c);
        end else if (move_c) begin
            word_d      = word_q >> 8;
            word_left_d = word_left_q - 3'd1;
            fetched_d   = fetched_q + CNT_W'(1);
            if (ff_pend_q) begin
                ff_pend_d = 1'b0;
                if (byte_c == 8'h00) begin
                    app_en_c = 1'b1;
                end else begin
                    marker_d = 1'b1;
                    mval_d   = byte_c;
                end
            end else if (byte_c == 8'hFF) begin
                ff_pend_d = 1'b1;
            end else begin
                app_en_c   = 1'b1;
                app_byte_c = byte_c;
            end
        end else if (eos_q && (pos_eff_c <= POS_W'(24))) begin
            app_en_c = 1'b1;
        end

        if (app_en_c) begin
            buf_d = (buf_q << 8) | BUF_W'(app_byte_c);
            pos_d = pos_eff_c + POS_W'(8);
        end

        if (active_q && (fetched_q == count_q) && !ff_pend_q && !marker_q) begin
            eos_d = 1'b1;
        end

        // A new stream overrides everything else happening this cycle.
        if (start) begin
            count_d     = ID_ByteCount;
            fetched_d   = '0;
            word_d      = '0;
            word_left_d = '0;
            buf_d       = '0;
            pos_d       = '0;
            ff_pend_d   = 1'b0;
            active_d    = 1'b1;
            marker_d    = 1'b0;
            mval_d      = '0;
            eos_d       = 1'b0;
            uflow_d     = 1'b0;
        end
    end

    assign bus.word_request = req_c;
    assign bus.peek_bits    = PEEK_W'({buf_q, 16'h0000} >> pos_q);
    assign bus.bits_valid   = (pos_q >= POS_W'(16)) || eos_q;
    assign marker_found     = marker_q;
    assign marker_value     = mval_q;
    assign end_of_stream    = eos_q;
    assign underflow_error  = uflow_q;

endmodule

// File: tb/tb_id_hd_bitstream_reader.sv
// Directed self-checking bench for id_hd_bitstream_reader with a peek-value scoreboard.
module tb_id_hd_bitstream_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] byte_count;
    logic        marker_found;
    logic [7:0]  marker_value;
    logic        end_of_stream;
    logic        underflow_error;

    int n_cmp;
    int n_err;
    logic [15:0] exp_q[$];

    id_hd_bitstream_reader_if bus ();

    id_hd_bitstream_reader #(.BUF_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .ID_ByteCount    (byte_count),
        .bus             (bus),
        .marker_found    (marker_found),
        .marker_value    (marker_value),
        .end_of_stream   (end_of_stream),
        .underflow_error (underflow_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed 0x%0h expected <empty scoreboard>", tag, bus.peek_bits);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(bus.peek_bits), 32'(e));
        end
    endtask

    // sel: 0 word_request, 1 bits_valid, 2 end_of_stream, 3 marker_found
    task automatic wait_on(input int sel, input string tag);
        int   n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 64) begin
            case (sel)
                0:       hit = bus.word_request;
                1:       hit = bus.bits_valid;
                2:       hit = end_of_stream;
                default: hit = marker_found;
            endcase
            if (!hit) begin
                @(negedge clk);
                n++;
            end
        end
        n_cmp++;
        assert (hit === 1'b1)
        else begin
            n_err++;
            $error("FAIL %s: observed timeout after %0d cycles expected event", tag, n);
        end
    endtask

    task automatic do_start(input logic [31:0] cnt);
        start      = 1'b1;
        byte_count = cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w, input string tag);
        wait_on(0, tag);
        bus.inputready = 1'b1;
        bus.readdata   = w;
        @(negedge clk);
        bus.inputready = 1'b0;
        bus.readdata   = 32'h0;
    endtask

    task automatic do_consume(input logic [4:0] len);
        bus.consume        = 1'b1;
        bus.consume_length = len;
        @(negedge clk);
        bus.consume        = 1'b0;
        bus.consume_length = 5'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        byte_count = 32'h0;
        bus.inputready = 1'b0;
        bus.readdata = 32'h0;
        bus.consume = 1'b0;
        bus.consume_length = 5'd0;
        idle(2);
        chk("rst_word_request", 32'(bus.word_request), 32'h0);
        chk("rst_peek", 32'(bus.peek_bits), 32'h0);
        chk("rst_flags", 32'({bus.bits_valid, marker_found, end_of_stream, underflow_error}), 32'h0);
        chk("rst_marker_value", 32'(marker_value), 32'h0);
        reset = 1'b0;
        idle(2);
        chk("idle_no_request", 32'(bus.word_request), 32'h0);

        // Basic word: 12 34 56 78
        do_start(32'd4);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        feed(32'h78563412, "basic_req");
        wait_on(1, "basic_valid");
        pop_chk("basic_first_peek");
        idle(4);
        chk("basic_pos_full", 32'(dut.pos_q), 32'd32);
        pop_chk("basic_peek_stable");
        do_consume(5'd16);
        pop_chk("basic_after_consume");
        chk("basic_eos", 32'(end_of_stream), 32'h1);
        chk("basic_no_uflow", 32'(underflow_error), 32'h0);

        // Stuffed FF 00 then A5
        do_start(32'd3);
        exp_q.push_back(16'hFFA5);
        exp_q.push_back(16'hFFA5);
        feed(32'h00A500FF, "stuff_req");
        wait_on(1, "stuff_valid");
        pop_chk("stuff_peek");
        idle(3);
        chk("stuff_fetched", dut.fetched_q, 32'd3);
        pop_chk("stuff_peek_padded");
        chk("stuff_marker", 32'(marker_found), 32'h0);

        // Marker: 12 FF D9
        do_start(32'd3);
        exp_q.push_back(16'h1200);
        exp_q.push_back(16'h1200);
        exp_q.push_back(16'h2000);
        feed(32'h00D9FF12, "mark_req");
        wait_on(3, "mark_found");
        chk("mark_value", 32'(marker_value), 32'hD9);
        chk("mark_pos", 32'(dut.pos_q), 32'd8);
        pop_chk("mark_peek");
        chk("mark_not_valid", 32'(bus.bits_valid), 32'h0);
        bus.inputready = 1'b1;
        bus.readdata = 32'h11111111;
        idle(3);
        bus.inputready = 1'b0;
        chk("mark_no_request", 32'(bus.word_request), 32'h0);
        chk("mark_ignore_ready", 32'(dut.pos_q), 32'd8);
        do_consume(5'd9);
        chk("uflow_set", 32'(underflow_error), 32'h1);
        pop_chk("uflow_pos_unchanged");
        do_consume(5'd4);
        pop_chk("mark_consume_after");

        // Consume coinciding with an append
        do_start(32'd4);
        feed(32'h44332211, "cons_req");
        @(negedge clk);
        chk("cons_first_byte", 32'(dut.pos_q), 32'd8);
        do_consume(5'd3);
        chk("cons_net_pos", 32'(dut.pos_q), 32'd13);
        chk("cons_net_peek", 32'(bus.peek_bits), 32'h8910);

        // Single byte with padding
        do_start(32'd1);
        exp_q.push_back(16'hABFF);
        feed(32'h000000AB, "one_req");
        wait_on(2, "one_eos");
        idle(2);
        pop_chk("one_peek_pad");
        chk("one_valid", 32'(bus.bits_valid), 32'h1);
        do_consume(5'd0);
        chk("len0_uflow", 32'(underflow_error), 32'h1);

        // Empty stream
        do_start(32'd0);
        chk("empty_uflow_cleared", 32'(underflow_error), 32'h0);
        chk("empty_eos_not_yet", 32'(end_of_stream), 32'h0);
        @(negedge clk);
        chk("empty_eos", 32'(end_of_stream), 32'h1);
        exp_q.push_back(16'hFFFF);
        idle(5);
        pop_chk("empty_pad_peek");
        do_consume(5'd17);
        chk("len17_uflow", 32'(underflow_error), 32'h1);
        chk("len17_pos", 32'(dut.pos_q), 32'd32);

        // Reset mid-word, then a fresh stream
        do_start(32'd4);
        feed(32'hDDCCBBAA, "rst_req");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_peek", 32'(bus.peek_bits), 32'h0);
        chk("midrst_flags", 32'({bus.word_request, bus.bits_valid, marker_found, end_of_stream, underflow_error}), 32'h0);
        idle(1);
        reset = 1'b0;
        idle(3);
        chk("post_rst_idle", 32'({bus.word_request, bus.bits_valid, end_of_stream}), 32'h0);
        do_start(32'd2);
        exp_q.push_back(16'h3C5A);
        feed(32'h00005A3C, "new_req");
        wait_on(1, "new_valid");
        pop_chk("new_stream_peek");
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
